multicycle_ctrl: RTL and testbench

- Next-generation multi-cycle CPU control FSM. Sequences IF/ID/EX/MEM/WB with valid/ready handshakes to instruction and data memory.
- Adds wait-state tolerance, per-transaction timeout trapping, halt on ebreak and trap on illegal instruction.
- Maintains cycle and retired-instruction counters.
- Sits between the datapath (PC, IR, regfile) and the memory interfaces.

---
 rtl/multicycle_ctrl_if.sv | 30 +++
 rtl/multicycle_ctrl.sv | 127 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Handshake and decode bundle between the multicycle controller and
// the memories / datapath it sequences.
interface multicycle_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic imem_rvalid;
  logic ir_we;
  logic dec_is_load;
  logic dec_is_store;
  logic dec_is_ebreak;
  logic dec_illegal;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;
  logic dmem_rvalid;
  logic reg_we;
  logic pc_we;

  modport master (
    output imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we,
    input  imem_ready, imem_rvalid, dmem_ready, dmem_rvalid,
    input  dec_is_load, dec_is_store, dec_is_ebreak, dec_illegal
  );

  modport slave (
    input  imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we,
    output imem_ready, imem_rvalid, dmem_ready, dmem_rvalid,
    output dec_is_load, dec_is_store, dec_is_ebreak, dec_illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: IF/ID/EX/MEM/WB sequencing with wait-state
// tolerance, transaction timeout trap, ebreak halt and cycle/retire counters.
module multicycle_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master bus,
  output logic             halt,
  output logic             trap,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] mcycle,
  output logic [CNT_W-1:0] minstret
);
  localparam int unsigned WAIT_W = 16;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6,
    S_TRAP = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic              acc_q, acc_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  mcycle_q, minstret_q;
  logic              req, accept, done, expired;

  // Next state, wait/accept tracking and combinational control outputs
  always_comb begin
    state_d          = state_q;
    acc_d            = acc_q;
    wait_d           = wait_q;
    req              = 1'b0;
    accept           = 1'b0;
    done             = 1'b0;
    expired          = ({1'b0, wait_q} + 17'd1) >= 17'(TIMEOUT);
    bus.imem_req     = 1'b0;
    bus.ir_we        = 1'b0;
    bus.dmem_req     = 1'b0;
    bus.dmem_we      = 1'b0;
    bus.reg_we       = 1'b0;
    bus.pc_we        = 1'b0;
    halt             = 1'b0;
    trap             = 1'b0;

    case (state_q)
      S_INIT: state_d = S_IF;
      S_IF: begin
        req          = ~acc_q;
        bus.imem_req = req;
        accept       = req & bus.imem_ready;
        done         = bus.imem_rvalid & (acc_q | accept);
        if (accept) acc_d = 1'b1;
        if (done) begin
          bus.ir_we = 1'b1;
          state_d   = S_ID;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (expired) state_d = S_TRAP;
        end
      end
      S_ID: begin
        if (bus.dec_illegal)        state_d = S_TRAP;
        else if (bus.dec_is_ebreak) state_d = S_HALT;
        else                        state_d = S_EX;
      end
      S_EX: state_d = (bus.dec_is_load | bus.dec_is_store) ? S_MEM : S_WB;
      S_MEM: begin
        req          = ~acc_q;
        bus.dmem_req = req;
        bus.dmem_we  = req & bus.dec_is_store;
        accept       = req & bus.dmem_ready;
        // Stores finish on acceptance; loads need read data at or after it
        done = bus.dec_is_store ? accept
                                : (bus.dmem_rvalid & (acc_q | accept));
        if (accept) acc_d = 1'b1;
        if (done) begin
          state_d = S_WB;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (expired) state_d = S_TRAP;
        end
      end
      S_WB: begin
        bus.reg_we = ~bus.dec_is_store;
        bus.pc_we  = 1'b1;
        state_d    = S_IF;
      end
      S_HALT: halt = 1'b1;
      S_TRAP: trap = 1'b1;
      default: state_d = S_INIT;
    endcase

    // Each new state starts a fresh transaction window
    if (state_d != state_q) begin
      acc_d  = 1'b0;
      wait_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_INIT;
      acc_q      <= 1'b0;
      wait_q     <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      wait_q  <= wait_d;
      if (state_q != S_INIT) mcycle_q <= mcycle_q + CNT_W'(1);
      if (state_q == S_WB)   minstret_q <= minstret_q + CNT_W'(1);
    end
  end

  assign state_o  = state_q;
  assign mcycle   = mcycle_q;
  assign minstret = minstret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a per-instruction timing model emits
// the expected observation for every cycle; a negedge monitor compares.
module tb_multicycle_ctrl;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TIMEOUT = 4;

  localparam logic [2:0] ST_INIT = 3'd0, ST_IF = 3'd1, ST_ID = 3'd2, ST_EX = 3'd3,
                         ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6, ST_TRAP = 3'd7;
  localparam int C_ALU = 0, C_LD = 1, C_ST = 2, C_EBR = 3, C_ILL = 4, C_BOTH = 5;

  typedef struct packed {
    logic [2:0]       st;
    logic             ireq;
    logic             irwe;
    logic             dreq;
    logic             dwe;
    logic             rwe;
    logic             pcwe;
    logic             hlt;
    logic             trp;
    logic [CNT_W-1:0] mcyc;
    logic [CNT_W-1:0] mret;
  } obs_t;

  logic             clk;
  logic             rst;
  logic             halt;
  logic             trap;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] mcycle;
  logic [CNT_W-1:0] minstret;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .halt     (halt),
    .trap     (trap),
    .state_o  (state_o),
    .mcycle   (mcycle),
    .minstret (minstret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t             exp_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] m_mcycle;
  logic [CNT_W-1:0] m_minstret;

  // Monitor: one expected observation per cycle, sampled mid-cycle
  always @(negedge clk) begin : monitor
    obs_t e;
    obs_t a;
    if (exp_q.size() != 0) begin
      e      = exp_q.pop_front();
      a.st   = state_o;
      a.ireq = bus.imem_req;
      a.irwe = bus.ir_we;
      a.dreq = bus.dmem_req;
      a.dwe  = bus.dmem_we;
      a.rwe  = bus.reg_we;
      a.pcwe = bus.pc_we;
      a.hlt  = halt;
      a.trp  = trap;
      a.mcyc = mcycle;
      a.mret = minstret;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL obs t=%0t: got st=%0d ireq=%b irwe=%b dreq=%b dwe=%b rwe=%b pcwe=%b halt=%b trap=%b mcycle=%0d minstret=%0d; exp st=%0d ireq=%b irwe=%b dreq=%b dwe=%b rwe=%b pcwe=%b halt=%b trap=%b mcycle=%0d minstret=%0d",
                 $time, a.st, a.ireq, a.irwe, a.dreq, a.dwe, a.rwe, a.pcwe, a.hlt, a.trp, a.mcyc, a.mret,
                 e.st, e.ireq, e.irwe, e.dreq, e.dwe, e.rwe, e.pcwe, e.hlt, e.trp, e.mcyc, e.mret);
      end
    end
  end

  // Push the expected view of the current cycle, advance the model counters
  task automatic emit(input logic [2:0] st, input logic ireq, input logic irwe,
                      input logic dreq, input logic dwe, input logic rwe, input logic pcwe);
    obs_t e;
    e.st   = st;
    e.ireq = ireq;
    e.irwe = irwe;
    e.dreq = dreq;
    e.dwe  = dwe;
    e.rwe  = rwe;
    e.pcwe = pcwe;
    e.hlt  = (st == ST_HALT);
    e.trp  = (st == ST_TRAP);
    e.mcyc = m_mcycle;
    e.mret = m_minstret;
    exp_q.push_back(e);
    if (st != ST_INIT) m_mcycle = m_mcycle + CNT_W'(1);
    if (pcwe) m_minstret = m_minstret + CNT_W'(1);
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    bus.imem_ready  = 1'($urandom);
    bus.imem_rvalid = 1'($urandom);
    bus.dmem_ready  = 1'($urandom);
    bus.dmem_rvalid = 1'($urandom);
  endtask

  task automatic rand_dec();
    bus.dec_is_load   = 1'($urandom);
    bus.dec_is_store  = 1'($urandom);
    bus.dec_is_ebreak = 1'($urandom);
    bus.dec_illegal   = 1'($urandom);
  endtask

  task automatic set_dec(input int cls);
    bus.dec_is_load   = (cls == C_LD);
    bus.dec_is_store  = (cls == C_ST);
    bus.dec_is_ebreak = (cls == C_EBR) || (cls == C_BOTH);
    bus.dec_illegal   = (cls == C_ILL) || (cls == C_BOTH);
  endtask

  task automatic tail(input logic [2:0] st, input int n);
    for (int k = 0; k < n; k++) begin
      noise();
      rand_dec();
      emit(st, 0, 0, 0, 0, 0, 0);
    end
  endtask

  // Asynchronous reset applied mid-cycle, with stray responses on the bus
  task automatic do_reset();
    rst        = 1'b0;
    m_mcycle   = '0;
    m_minstret = '0;
    for (int k = 0; k < 2; k++) begin
      noise();
      bus.dmem_rvalid = 1'b1;
      bus.imem_rvalid = 1'b1;
      emit(ST_INIT, 0, 0, 0, 0, 0, 0);
    end
    rst = 1'b1;
    noise();
    bus.dmem_rvalid = 1'b1;
    emit(ST_INIT, 0, 0, 0, 0, 0, 0);
  endtask

  // One instruction: rd/dr = cycles before ready, vd/dv = rvalid lag after accept
  task automatic run_instr(input int cls, input int rd, input int vd, input int dr,
                           input int dv, input bit abort_mem, output bit ended);
    int n;
    int last;
    bit to;
    ended = 1'b0;
    last  = rd + vd;
    to    = (last >= int'(TIMEOUT));
    n     = to ? int'(TIMEOUT) : last + 1;
    for (int k = 0; k < n; k++) begin
      noise();
      rand_dec();
      bus.imem_ready  = (k < rd) ? 1'b0 : ((k == rd) ? 1'b1 : 1'($urandom));
      bus.imem_rvalid = (k == last) ? 1'b1 : ((k < rd) ? 1'($urandom) : 1'b0);
      emit(ST_IF, k <= rd, !to && (k == n - 1), 0, 0, 0, 0);
    end
    if (to) begin
      tail(ST_TRAP, 3);
      ended = 1'b1;
      return;
    end
    set_dec(cls);
    noise();
    emit(ST_ID, 0, 0, 0, 0, 0, 0);
    if (cls == C_ILL || cls == C_BOTH) begin
      tail(ST_TRAP, 4);
      ended = 1'b1;
      return;
    end
    if (cls == C_EBR) begin
      tail(ST_HALT, 20);
      ended = 1'b1;
      return;
    end
    noise();
    emit(ST_EX, 0, 0, 0, 0, 0, 0);
    if (cls == C_LD || cls == C_ST) begin
      last = (cls == C_ST) ? dr : dr + dv;
      to   = (last >= int'(TIMEOUT));
      n    = to ? int'(TIMEOUT) : last + 1;
      for (int k = 0; k < n; k++) begin
        noise();
        bus.dmem_ready = (k < dr) ? 1'b0 : ((k == dr) ? 1'b1 : 1'($urandom));
        if (cls == C_LD)
          bus.dmem_rvalid = (k == last) ? 1'b1 : ((k < dr) ? 1'($urandom) : 1'b0);
        emit(ST_MEM, 0, 0, k <= dr, (cls == C_ST) && (k <= dr), 0, 0);
        if (abort_mem) begin
          ended = 1'b1;
          return;
        end
      end
      if (to) begin
        tail(ST_TRAP, 3);
        ended = 1'b1;
        return;
      end
    end
    noise();
    emit(ST_WB, 0, 0, 0, 0, cls != C_ST, 1);
  endtask

  function automatic int pick_delay(input bit allow_to);
    if (allow_to && $urandom_range(0, 9) == 0)
      return int'($urandom_range(TIMEOUT, TIMEOUT + 2));
    return int'($urandom_range(0, 2));
  endfunction

  initial begin : stim
    bit e;
    int cls;
    int r;
    rst = 1'b0;
    m_mcycle   = '0;
    m_minstret = '0;
    bus.imem_ready = 0; bus.imem_rvalid = 0; bus.dmem_ready = 0; bus.dmem_rvalid = 0;
    set_dec(C_ALU);
    @(posedge clk);
    #1;
    do_reset();

    // Directed: zero-wait ALU x2, load with waits, zero-wait store, boundary completions
    run_instr(C_ALU, 0, 0, 0, 0, 0, e);
    run_instr(C_ALU, 0, 0, 0, 0, 0, e);
    run_instr(C_LD,  0, 0, 2, 1, 0, e);
    run_instr(C_ST,  0, 0, 0, 0, 0, e);
    run_instr(C_ALU, 2, 1, 0, 0, 0, e);
    run_instr(C_LD,  1, 0, 3, 0, 0, e);
    run_instr(C_ST,  0, 0, 3, 0, 0, e);
    // Fetch timeout with imem_ready held low
    run_instr(C_ALU, TIMEOUT + 3, 0, 0, 0, 0, e);
    do_reset();
    run_instr(C_ALU, 0, 0, 0, 0, 0, e);
    run_instr(C_EBR, 0, 0, 0, 0, 0, e);
    do_reset();
    run_instr(C_BOTH, 1, 1, 0, 0, 0, e);
    do_reset();
    run_instr(C_ILL, 0, 0, 0, 0, 0, e);
    // Reset while a load waits in MEM
    do_reset();
    run_instr(C_ALU, 0, 0, 0, 0, 0, e);
    run_instr(C_LD,  0, 0, 3, 1, 1, e);
    do_reset();
    run_instr(C_ALU, 0, 0, 0, 0, 0, e);
    // Data-side timeouts for store and load
    run_instr(C_ST, 0, 0, TIMEOUT, 0, 0, e);
    do_reset();
    run_instr(C_LD, 0, 0, 1, 3, 0, e);

    // Long run so both counters wrap
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cls = int'($urandom_range(0, 2));
      run_instr(cls, pick_delay(0), int'($urandom_range(0, 1)),
                pick_delay(0), int'($urandom_range(0, 1)), 0, e);
    end

    // Random programs ending in halt, trap or a reset
    for (int run = 0; run < 25; run++) begin
      do_reset();
      for (int i = 0; i < 30; i++) begin
        r = int'($urandom_range(0, 99));
        cls = (r < 40) ? C_ALU : (r < 65) ? C_LD : (r < 90) ? C_ST :
              (r < 94) ? C_EBR : (r < 98) ? C_ILL : C_BOTH;
        run_instr(cls, pick_delay(1), int'($urandom_range(0, 2)),
                  pick_delay(1), int'($urandom_range(0, 2)), 0, e);
        if (e) break;
      end
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected observations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
